// File: rtl/matrix_op_sequencer.sv
// Instruction sequencer for the matrix ALU: fetches operand rows from RAM, runs the ALU,
// writes the 5x5 result back, and also performs direct row LOAD/STORE for the host.
module matrix_op_sequencer #(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [39:0]       data_in,
    output logic [39:0]       data_out,
    output logic              op_done,
    output logic              op_error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [39:0]       mem_wdata,
    input  logic [39:0]       mem_rdata,
    output logic [3:0]        alu_opcode,
    output logic [7:0]        alu_scalar,
    output logic [199:0]      alu_matrizA,
    output logic [199:0]      alu_matrizB,
    output logic              alu_start,
    input  logic [199:0]      alu_result,
    input  logic              alu_done
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);

    typedef enum logic [3:0] {
        StIdle, StLoad, StStoreRd, StStoreCap, StFetchA, StFetchB, StExec, StWrite, StDone
    } state_e;

    state_e         state_q, state_d;
    logic [26:0]    instr_q, instr_d;
    logic [39:0]    ld_q, ld_d;
    logic [39:0]    dout_q, dout_d;
    logic [2:0]     cnt_q, cnt_d;
    logic [WdW-1:0] wd_q, wd_d;
    logic           err_q, err_d;
    logic [199:0]   mat_a_q, mat_a_d, mat_b_q, mat_b_d, res_q, res_d;
    logic [ADDR_W-1:0] fetch_base;
    logic           unused_rsvd;

    assign unused_rsvd = ^instr[31:27];

    function automatic logic is_binary(input logic [3:0] op);
        return (op >= 4'h3) && (op <= 4'h5);
    endfunction

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= 4'h3) && (op <= 4'hc);
    endfunction

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        ld_d        = ld_q;
        dout_d      = dout_q;
        cnt_d       = cnt_q;
        wd_d        = wd_q;
        err_d       = err_q;
        mat_a_d     = mat_a_q;
        mat_b_d     = mat_b_q;
        res_d       = res_q;
        instr_ready = 1'b0;
        op_done     = 1'b0;
        op_error    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        alu_start   = 1'b0;
        fetch_base  = (state_q == StFetchB) ? ADDR_W'(instr_q[13:9]) : ADDR_W'(instr_q[8:4]);

        unique case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                err_d       = 1'b0;
                if (instr_valid) begin
                    instr_d = instr[26:0];
                    ld_d    = data_in;
                    cnt_d   = '0;
                    wd_d    = '0;
                    mat_b_d = '0;
                    if (instr[3:0] == 4'h1) begin
                        state_d = StLoad;
                    end else if (instr[3:0] == 4'h2) begin
                        state_d = StStoreRd;
                    end else if (is_alu_op(instr[3:0])) begin
                        state_d = StFetchA;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end
                end
            end
            StLoad: begin
                mem_we    = 1'b1;
                mem_addr  = ADDR_W'(instr_q[8:4]);
                mem_wdata = ld_q;
                state_d   = StDone;
            end
            StStoreRd: begin
                mem_addr = ADDR_W'(instr_q[8:4]);
                state_d  = StStoreCap;
            end
            StStoreCap: begin
                dout_d  = mem_rdata;
                state_d = StDone;
            end
            StFetchA, StFetchB: begin
                if (cnt_q != 3'd5) mem_addr = fetch_base + ADDR_W'(cnt_q);
                // Read data lags the address by one cycle, so cycle k fills row k-1.
                for (int i = 0; i < 5; i++) begin
                    if (cnt_q == 3'(i + 1)) begin
                        if (state_q == StFetchA) mat_a_d[199-40*i -: 40] = mem_rdata;
                        else                     mat_b_d[199-40*i -: 40] = mem_rdata;
                    end
                end
                if (cnt_q == 3'd5) begin
                    cnt_d   = '0;
                    state_d = (state_q == StFetchA && is_binary(instr_q[3:0])) ? StFetchB : StExec;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            StExec: begin
                alu_start = 1'b1;
                if (alu_done) begin
                    res_d   = alu_result;
                    cnt_d   = '0;
                    state_d = StWrite;
                end else if (wd_q == WdW'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    wd_d = wd_q + WdW'(1);
                end
            end
            StWrite: begin
                mem_we   = 1'b1;
                mem_addr = ADDR_W'(instr_q[18:14]) + ADDR_W'(cnt_q);
                for (int i = 0; i < 5; i++) begin
                    if (cnt_q == 3'(i)) mem_wdata = res_q[199-40*i -: 40];
                end
                if (cnt_q == 3'd4) state_d = StDone;
                else               cnt_d   = cnt_q + 3'd1;
            end
            StDone: begin
                op_done  = 1'b1;
                op_error = err_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            instr_q <= '0;
            ld_q    <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            mat_a_q <= '0;
            mat_b_q <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            ld_q    <= ld_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
            res_q   <= res_d;
        end
    end

    assign alu_opcode  = instr_q[3:0];
    assign alu_scalar  = instr_q[26:19];
    assign alu_matrizA = mat_a_q;
    assign alu_matrizB = mat_b_q;
    assign data_out    = dout_q;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Randomised bench for matrix_op_sequencer with a RAM model, a configurable ALU model and a
// reference model built from instruction-level rules.
module tb_matrix_op_sequencer;

    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned TIMEOUT = 255;

    logic              clk;
    logic              rst_n;
    logic [31:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [39:0]       data_in;
    logic [39:0]       data_out;
    logic              op_done;
    logic              op_error;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [39:0]       mem_wdata;
    logic [39:0]       mem_rdata;
    logic [3:0]        alu_opcode;
    logic [7:0]        alu_scalar;
    logic [199:0]      alu_matrizA;
    logic [199:0]      alu_matrizB;
    logic              alu_start;
    logic [199:0]      alu_result;
    logic              alu_done;

    matrix_op_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .data_in    (data_in),
        .data_out   (data_out),
        .op_done    (op_done),
        .op_error   (op_error),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .alu_opcode (alu_opcode),
        .alu_scalar (alu_scalar),
        .alu_matrizA(alu_matrizA),
        .alu_matrizB(alu_matrizB),
        .alu_start  (alu_start),
        .alu_result (alu_result),
        .alu_done   (alu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [39:0] ram   [32];
    logic [39:0] model [32];
    logic [39:0] exp_dout;
    bit          ram_valid;
    int          alu_delay;
    bit          alu_never;
    int          alu_cnt;

    // Element-wise sum with scalar; the sequencer only moves data, so any fixed rule will do.
    function automatic logic [199:0] alu_fn(input logic [199:0] a, input logic [199:0] b,
                                            input logic [7:0] s);
        logic [199:0] r;
        for (int i = 0; i < 25; i++) r[i*8 +: 8] = a[i*8 +: 8] + b[i*8 +: 8] + s;
        return r;
    endfunction

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] r,
                                       input logic [7:0] s);
        return {5'b0, s, r, b, a, op};
    endfunction

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_done   <= 1'b0;
            alu_cnt    <= 0;
            alu_result <= '0;
        end else if (alu_start && !alu_done) begin
            if (!alu_never && alu_cnt == alu_delay) begin
                alu_done   <= 1'b1;
                alu_result <= alu_fn(alu_matrizA, alu_matrizB, alu_scalar);
            end else begin
                alu_cnt <= alu_cnt + 1;
            end
        end else if (!alu_start) begin
            alu_done <= 1'b0;
            alu_cnt  <= 0;
        end
    end

    task automatic check_eq(input string tag, input logic [199:0] got, input logic [199:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] ins, input logic [39:0] din, input int delay,
                          input bit never, input int abort_we);
        logic [3:0]   op;
        logic [4:0]   fa, fb, fr;
        logic [7:0]   sc;
        logic [199:0] exp_a, exp_b, exp_res, got_a, got_b;
        logic [3:0]   got_op;
        logic [7:0]   got_sc;
        int           cycles, st_cnt, we_cnt, acc, exp_lat, exp_we, exp_st, n_wr, n_spur;
        bit           done, aborted, got_err, exp_err, is_alu, is_bin;
        op = ins[3:0]; fa = ins[8:4]; fb = ins[13:9]; fr = ins[18:14]; sc = ins[26:19];
        is_bin = (op >= 3 && op <= 5);
        is_alu = (op >= 3 && op <= 12);
        cycles = 0; st_cnt = 0; we_cnt = 0; n_wr = 0; n_spur = 0;
        done = 0; aborted = 0; got_err = 0;
        got_a = '0; got_b = '0; got_op = '0; got_sc = '0; exp_a = '0; exp_b = '0; exp_res = '0;
        alu_delay = delay;
        alu_never = never;
        @(negedge clk);
        check_eq("idle_ready", instr_ready, 1);
        check_eq("idle_done", op_done, 0);
        check_eq("idle_error", op_error, 0);
        instr = ins; data_in = din; instr_valid = 1'b1; acc = 1;
        while (!done && cycles < 600) begin
            @(negedge clk);
            cycles++;
            data_in = {$urandom, 8'($urandom)};
            if (instr_valid && instr_ready) acc++;
            if (alu_start) begin
                st_cnt++;
                got_a = alu_matrizA; got_b = alu_matrizB; got_op = alu_opcode; got_sc = alu_scalar;
            end
            if (mem_we) begin
                we_cnt++;
                if (abort_we != 0 && we_cnt == abort_we) begin
                    rst_n = 1'b0;
                    #1;
                    check_eq("rst_mem_we", mem_we, 0);
                    check_eq("rst_alu_start", alu_start, 0);
                    check_eq("rst_ready", instr_ready, 1);
                    check_eq("rst_mem_addr", mem_addr, 0);
                    aborted = 1; done = 1;
                end
            end
            if (op_done) begin
                got_err = op_error;
                done = 1;
            end
        end
        instr_valid = 1'b0;
        if (!done) check_eq("op_cycle_budget", cycles, 0);

        exp_err = 0; exp_we = 0; exp_st = 0; exp_lat = 0;
        if (op == 4'h1) begin
            exp_lat = 2; exp_we = 1; model[fa] = din;
        end else if (op == 4'h2) begin
            exp_lat = 3; exp_dout = model[fa];
        end else if (is_alu) begin
            for (int i = 0; i < 5; i++) begin
                exp_a[199-40*i -: 40] = model[(int'(fa) + i) % 32];
                if (is_bin) exp_b[199-40*i -: 40] = model[(int'(fb) + i) % 32];
            end
            exp_lat = is_bin ? 12 : 6;
            if (never) begin
                exp_st = TIMEOUT; exp_err = 1; exp_lat += TIMEOUT + 1;
            end else begin
                exp_st = delay + 2; exp_we = 5; exp_lat += delay + 2 + 6; n_wr = 5;
                exp_res = alu_fn(exp_a, exp_b, sc);
            end
        end else begin
            exp_lat = 1; exp_err = 1;
        end
        if (aborted) n_wr = abort_we - 1;
        for (int i = 0; i < n_wr; i++) model[(int'(fr) + i) % 32] = exp_res[199-40*i -: 40];

        if (aborted) begin
            exp_dout = '0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            repeat (4) begin
                @(negedge clk);
                if (op_done) n_spur++;
            end
            check_eq("rst_no_done", n_spur, 0);
            check_eq("rst_ready_after", instr_ready, 1);
            check_eq("rst_matA", alu_matrizA, 0);
        end else begin
            check_eq("latency", cycles, exp_lat);
            check_eq("op_error", got_err, exp_err);
            check_eq("we_cycles", we_cnt, exp_we);
            check_eq("start_cycles", st_cnt, exp_st);
            check_eq("accepts", acc, 1);
            if (exp_st > 0) begin
                check_eq("alu_matA", got_a, exp_a);
                check_eq("alu_matB", got_b, exp_b);
                check_eq("alu_opcode", got_op, op);
                check_eq("alu_scalar", got_sc, sc);
            end
        end
        check_eq("data_out", data_out, exp_dout);
        if (ram_valid) for (int i = 0; i < 32; i++) check_eq("ram_row", ram[i], model[i]);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b1; instr = '0; instr_valid = 1'b0; data_in = '0;
        alu_delay = 0; alu_never = 0; exp_dout = '0; ram_valid = 0;
        #1 rst_n = 1'b0;
        #11;
        check_eq("rst_instr_ready", instr_ready, 1);
        check_eq("rst_op_done", op_done, 0);
        check_eq("rst_op_error", op_error, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_alu_start", alu_start, 0);
        check_eq("rst_alu_opcode", alu_opcode, 0);
        check_eq("rst_alu_scalar", alu_scalar, 0);
        check_eq("rst_matA", alu_matrizA, 0);
        check_eq("rst_matB", alu_matrizB, 0);
        check_eq("rst_data_out", data_out, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(mk(4'h1, 5'd3, 5'd0, 5'd0, 8'd0), 40'h0102030405, 0, 0, 0);
        run_op(mk(4'h2, 5'd3, 5'd0, 5'd0, 8'd0), 40'h0, 0, 0, 0);
        check_eq("store_row3", data_out, 40'h0102030405);

        for (int i = 0; i < 32; i++)
            run_op(mk(4'h1, 5'(i), 5'd0, 5'd0, 8'd0),
                   (i < 10) ? 40'h0101010101 : {$urandom, 8'($urandom)}, 0, 0, 0);
        ram_valid = 1;

        run_op(mk(4'h3, 5'd0, 5'd5, 5'd10, 8'd0), 40'h0, 0, 0, 0);
        for (int i = 10; i < 15; i++) check_eq("bin_result_row", ram[i], 40'h0202020202);

        run_op(mk(4'h8, 5'd30, 5'd0, 5'd29, 8'd3), 40'h0, 3, 0, 0);
        run_op(mk(4'h6, 5'd7, 5'd0, 5'd20, 8'd9), 40'h0, 0, 1, 0);
        run_op(mk(4'hf, 5'd1, 5'd2, 5'd3, 8'd4), 40'h0, 0, 0, 0);
        run_op(mk(4'h0, 5'd1, 5'd2, 5'd3, 8'd4), 40'h0, 0, 0, 0);
        run_op(mk(4'hd, 5'd1, 5'd2, 5'd3, 8'd4), 40'h0, 0, 0, 0);

        for (int n = 0; n < 40; n++)
            run_op($urandom, {$urandom, 8'($urandom)}, int'($urandom_range(0, 6)), 0, 0);

        run_op(mk(4'h4, 5'd1, 5'd2, 5'd3, 8'd5), 40'h0, 1, 0, 2);
        run_op(mk(4'h1, 5'd9, 5'd0, 5'd0, 8'd0), 40'h00a1b2c3d4, 0, 0, 0);
        run_op(mk(4'h2, 5'd9, 5'd0, 5'd0, 8'd0), 40'h0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
